branch_target_predictor: RTL and testbench
==========================================

// Module: branch_target_predictor
// PURPOSE
//  Parametrised branch target buffer (BTB) with per-entry saturating direction counters, replacing static
//  predict-not-taken with EX-stage flush. Fetch looks up the current pc in the same cycle and gets a
//  predicted next pc. EX resolves each branch and sends an update. The block reports mispredict and the
//  redirect pc, and keeps saturating hit and mispredict statistics.
// PARAMETERS
//  ADDR_W    16   pc / target width; instructions are 2-byte aligned (pc[0] ignored)
//  ENTRIES   16   BTB entries, power of 2 >= 2; IDX_W = log2(ENTRIES)
//  CTR_W     2    direction counter width, >= 1; predict taken when counter MSB = 1
//  STAT_W    16   width of the statistics counters
// PORTS
//  clk              in   1       clock, all state on rising edge
//  rst              in   1       asynchronous, active-high reset
//  if_pc            in   ADDR_W  fetch-stage pc to predict
//  pred_hit         out  1       valid entry whose tag matches if_pc
//  pred_taken       out  1       pred_hit & counter MSB
//  pred_next_pc     out  ADDR_W  pred_taken ? stored target : if_pc+2
//  upd_valid        in   1       EX-stage resolution valid this cycle (low on stall/flushed slot)
//  upd_pc           in   ADDR_W  pc of resolved instruction
//  upd_is_branch    in   1       resolved instruction is B/BR
//  upd_taken        in   1       actual direction
//  upd_target       in   ADDR_W  actual target when taken
//  upd_pred_taken   in   1       prediction carried down the pipe with the instruction
//  upd_pred_target  in   ADDR_W  predicted next pc carried down the pipe
//  mispredict       out  1       combinational; flush IF/ID and ID/EX and load redirect_pc
//  redirect_pc      out  ADDR_W  upd_taken ? upd_target : upd_pc+2
//  invalidate_all   in   1       synchronous clear of every valid bit
//  stat_hits        out  STAT_W  count of cycles with pred_hit=1
//  stat_mispredicts out  STAT_W  count of cycles with mispredict=1
// BEHAVIOUR
//  - Indexing: idx = pc[IDX_W:1]; tag = pc[ADDR_W-1:IDX_W+1]. Entry = {valid, tag, target, ctr}.
//  - Lookup: combinational from flopped arrays, zero latency. No bypass: an update to the same entry in
//    the same cycle is visible from the next cycle.
//  - pc+2 wraps modulo 2^ADDR_W (0xFFFE+2 = 0x0000).
//  - mispredict = upd_valid & ( upd_is_branch ? (upd_taken != upd_pred_taken)
//    | (upd_taken & upd_pred_target != upd_target) : upd_pred_taken ).
//    It is 0 whenever upd_valid = 0.
//  - Update, on clk when upd_valid=1 and invalidate_all=0; hit = valid & tag match at idx(upd_pc):
//    * branch, hit: ctr +1 if taken, -1 if not taken, saturating at 0 and 2^CTR_W-1.
//      Target is overwritten when taken.
//    * branch, miss, taken: allocate (overwrite any alias). Set valid=1, tag, target, ctr = 2^(CTR_W-1).
//    * branch, miss, not taken: no change.
//    * non-branch, hit: clear valid (stale entry).
//  - invalidate_all clears all valid bits next edge and overrides a same-cycle update.
//    Counters, targets and statistics are untouched.
//  - Statistics increment by 1 per qualifying cycle and saturate at 2^STAT_W-1 (no wrap).
//    Only rst clears them.
//  - Reset (async): all valid=0, ctr=2^(CTR_W-1)-1 (weakly not taken), targets/tags=0, stats=0.
//    Hence pred_hit=0, pred_taken=0, pred_next_pc=if_pc+2, mispredict=0 while upd_valid=0.
//  - Reset mid-operation discards all entries at once; no partial state is kept.
// TESTING (ENTRIES=16, CTR_W=2)
//  1. After rst, if_pc=0x0010 -> pred_hit=0, pred_taken=0, pred_next_pc=0x0012, stats=0.
//  2. Update pc=0x0020, branch, taken, target=0x0040, pred_taken=0 -> mispredict=1, redirect_pc=0x0040.
//     Next cycle if_pc=0x0020 -> hit=1, taken=1, next_pc=0x0040. stat_mispredicts=1.
//  3. Then 3 not-taken updates to 0x0020 -> ctr 2->1->0->0 (saturates). pred_taken=0 after the first.
//     Taken update -> ctr=1, still not taken.
//  4. Alias: taken update pc=0x0060 (idx 0, different tag), target 0x0100 -> lookup 0x0020 misses.
//     Lookup 0x0060 -> next_pc=0x0100.
//  5. invalidate_all=1 with a same-cycle taken update at 0x0080 -> next cycle every lookup misses,
//     including 0x0080. Stats unchanged.
//  6. Lookup 0x0020 and update to 0x0020 in the same cycle -> old prediction that cycle, new one next.
//     Assert rst mid-run -> all misses immediately.

Source files
------------

// File: rtl/branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_predictor
// Description : Direct-mapped branch target buffer with per-entry saturating
//               direction counters. Fetch gets a same-cycle predicted next pc
//               for if_pc. EX sends one resolution per cycle. The block flags
//               mispredicts, supplies the redirect pc and keeps saturating
//               hit and mispredict statistics.
// Ports       : clk, rst (async, active high)
//               if_pc -> pred_hit / pred_taken / pred_next_pc   (lookup)
//               upd_*                                            (EX update)
//               mispredict / redirect_pc                         (EX outputs)
//               invalidate_all                                   (clear valids)
//               stat_hits / stat_mispredicts                     (statistics)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_predictor #(
    parameter int ADDR_W  = 16,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_next_pc,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_is_branch,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    input  logic              invalidate_all,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 1;

    localparam logic [CTR_W-1:0]  C_CTR_MAX   = '1;
    localparam logic [CTR_W-1:0]  C_CTR_ZERO  = '0;
    localparam logic [CTR_W-1:0]  C_CTR_ALLOC = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0]  C_CTR_RST   = C_CTR_ALLOC - CTR_W'(1);
    localparam logic [STAT_W-1:0] C_STAT_MAX  = '1;
    localparam logic [ADDR_W-1:0] C_PC_STEP   = ADDR_W'(2);

    // Entry storage
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q   [ENTRIES];
    logic [TAG_W-1:0]   tag_d   [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q   [ENTRIES];
    logic [ADDR_W-1:0]  tgt_d   [ENTRIES];
    logic [CTR_W-1:0]   ctr_q   [ENTRIES];
    logic [CTR_W-1:0]   ctr_d   [ENTRIES];
    logic [STAT_W-1:0]  stat_hits_q, stat_hits_d;
    logic [STAT_W-1:0]  stat_mis_q,  stat_mis_d;

    // Lookup path: purely combinational from the flopped arrays
    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;

    assign w_if_idx     = if_pc[IDX_W:1];
    assign w_if_tag     = if_pc[ADDR_W-1:IDX_W+1];
    assign pred_hit     = valid_q[w_if_idx] && (tag_q[w_if_idx] == w_if_tag);
    assign pred_taken   = pred_hit && ctr_q[w_if_idx][CTR_W-1];
    assign pred_next_pc = pred_taken ? tgt_q[w_if_idx] : (if_pc + C_PC_STEP);

    // Resolution path
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;

    assign w_upd_idx = upd_pc[IDX_W:1];
    assign w_upd_tag = upd_pc[ADDR_W-1:IDX_W+1];
    assign w_upd_hit = valid_q[w_upd_idx] && (tag_q[w_upd_idx] == w_upd_tag);

    // A non-branch that was predicted taken must also be flushed.
    assign mispredict = upd_valid &&
                        (upd_is_branch ?
                            ((upd_taken != upd_pred_taken) ||
                             (upd_taken && (upd_pred_target != upd_target))) :
                            upd_pred_taken);
    assign redirect_pc = upd_taken ? upd_target : (upd_pc + C_PC_STEP);

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        if (invalidate_all) begin
            // Wins over any same-cycle update; only valid bits are touched.
            valid_d = '0;
        end else if (upd_valid) begin
            if (upd_is_branch) begin
                if (w_upd_hit) begin
                    if (upd_taken) begin
                        tgt_d[w_upd_idx] = upd_target;
                        if (ctr_q[w_upd_idx] != C_CTR_MAX) begin
                            ctr_d[w_upd_idx] = ctr_q[w_upd_idx] + CTR_W'(1);
                        end
                    end else if (ctr_q[w_upd_idx] != C_CTR_ZERO) begin
                        ctr_d[w_upd_idx] = ctr_q[w_upd_idx] - CTR_W'(1);
                    end
                end else if (upd_taken) begin
                    // Allocation silently evicts whatever alias held the slot.
                    valid_d[w_upd_idx] = 1'b1;
                    tag_d[w_upd_idx]   = w_upd_tag;
                    tgt_d[w_upd_idx]   = upd_target;
                    ctr_d[w_upd_idx]   = C_CTR_ALLOC;
                end
            end else if (w_upd_hit) begin
                // Code at this pc is no longer a branch: drop the stale entry.
                valid_d[w_upd_idx] = 1'b0;
            end
        end
    end

    always_comb begin
        stat_hits_d = stat_hits_q;
        stat_mis_d  = stat_mis_q;
        if (pred_hit && (stat_hits_q != C_STAT_MAX)) begin
            stat_hits_d = stat_hits_q + STAT_W'(1);
        end
        if (mispredict && (stat_mis_q != C_STAT_MAX)) begin
            stat_mis_d = stat_mis_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            stat_hits_q <= '0;
            stat_mis_q  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= C_CTR_RST;
            end
        end else begin
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            tgt_q       <= tgt_d;
            ctr_q       <= ctr_d;
            stat_hits_q <= stat_hits_d;
            stat_mis_q  <= stat_mis_d;
        end
    end

    assign stat_hits        = stat_hits_q;
    assign stat_mispredicts = stat_mis_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_target_predictor
// Description : Self-checking bench for branch_target_predictor. A reference
//               model predicts every output each cycle; expectations are
//               queued when stimulus is applied and popped when the DUT
//               outputs are sampled. Small statistics width exercises
//               saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_predictor;

    localparam int C_STAT_W = 4;
    localparam int C_SMAX   = (1 << C_STAT_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] if_pc = '0;
    logic        pred_hit, pred_taken, mispredict;
    logic [15:0] pred_next_pc, redirect_pc;
    logic        upd_valid = 1'b0, upd_is_branch = 1'b0, upd_taken = 1'b0;
    logic        upd_pred_taken = 1'b0, invalidate_all = 1'b0;
    logic [15:0] upd_pc = '0, upd_target = '0, upd_pred_target = '0;
    logic [C_STAT_W-1:0] stat_hits, stat_mispredicts;

    branch_target_predictor #(
        .ADDR_W (16), .ENTRIES(16), .CTR_W(2), .STAT_W(C_STAT_W)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .if_pc           (if_pc),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_next_pc    (pred_next_pc),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_is_branch   (upd_is_branch),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .invalidate_all  (invalidate_all),
        .stat_hits       (stat_hits),
        .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic        taken;
        logic [15:0] npc;
        logic        mis;
        logic [15:0] rpc;
        int          sh;
        int          sm;
    } exp_t;

    exp_t q_exp[$];
    exp_t last_e;

    // Reference model state
    logic        m_valid [16];
    logic [10:0] m_tag   [16];
    logic [15:0] m_tgt   [16];
    int          m_ctr   [16];
    int          m_hits, m_mis;

    int n_checks = 0;
    int n_errors = 0;

    // Snapshot of the most recent sampled DUT outputs for directed checks
    logic        s_hit, s_taken, s_mis;
    logic [15:0] s_npc, s_rpc;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_hits = 0;
        m_mis  = 0;
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        int   i;
        i       = int'(if_pc[4:1]);
        e.hit   = m_valid[i] && (m_tag[i] == if_pc[15:5]);
        e.taken = e.hit && (m_ctr[i] >= 2);
        e.npc   = e.taken ? m_tgt[i] : 16'(if_pc + 16'd2);
        if (!upd_valid)        e.mis = 1'b0;
        else if (upd_is_branch) e.mis = (upd_taken != upd_pred_taken) ||
                                        (upd_taken && (upd_pred_target != upd_target));
        else                   e.mis = upd_pred_taken;
        e.rpc = upd_taken ? upd_target : 16'(upd_pc + 16'd2);
        e.sh  = m_hits;
        e.sm  = m_mis;
        return e;
    endfunction

    task automatic model_clock();
        int  i;
        logic h;
        if (last_e.hit && m_hits < C_SMAX) m_hits++;
        if (last_e.mis && m_mis  < C_SMAX) m_mis++;
        i = int'(upd_pc[4:1]);
        h = m_valid[i] && (m_tag[i] == upd_pc[15:5]);
        if (invalidate_all) begin
            for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
        end else if (upd_valid) begin
            if (upd_is_branch && h) begin
                if (upd_taken) begin
                    m_tgt[i] = upd_target;
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (upd_is_branch && upd_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = upd_pc[15:5];
                m_tgt[i]   = upd_target;
                m_ctr[i]   = 2;
            end else if (!upd_is_branch && h) begin
                m_valid[i] = 1'b0;
            end
        end
    endtask

    // Push the model's expectation for the current inputs, then pop and
    // compare against what the DUT shows.
    task automatic sample_and_check();
        exp_t e;
        last_e = model_exp();
        q_exp.push_back(last_e);
        e = q_exp.pop_front();
        s_hit = pred_hit; s_taken = pred_taken; s_npc = pred_next_pc;
        s_mis = mispredict; s_rpc = redirect_pc;
        chk("pred_hit",     pred_hit,         e.hit);
        chk("pred_taken",   pred_taken,       e.taken);
        chk("pred_next_pc", pred_next_pc,     e.npc);
        chk("mispredict",   mispredict,       e.mis);
        if (upd_valid) chk("redirect_pc", redirect_pc, e.rpc);
        chk("stat_hits",    stat_hits,        32'(e.sh));
        chk("stat_mis",     stat_mispredicts, 32'(e.sm));
    endtask

    // One cycle: drive at negedge, sample 1ns later, model steps at posedge.
    task automatic cyc(input logic [15:0] ipc, input logic uv, input logic [15:0] upc,
                       input logic br, input logic tk, input logic [15:0] tgt,
                       input logic ptk, input logic [15:0] ptgt, input logic inv);
        @(negedge clk);
        if_pc = ipc; upd_valid = uv; upd_pc = upc; upd_is_branch = br;
        upd_taken = tk; upd_target = tgt; upd_pred_taken = ptk;
        upd_pred_target = ptgt; invalidate_all = inv;
        #1;
        sample_and_check();
        @(posedge clk);
        if (!rst) model_clock();
    endtask

    task automatic look(input logic [15:0] ipc);
        cyc(ipc, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        #1;
        last_e = model_exp();
        chk("rst_hit", pred_hit, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1. Reset state
        look(16'h0010);
        chk("t1_npc",  s_npc, 16'h0012);
        chk("t1_hit",  s_hit, 1'b0);

        // 2. First taken branch allocates
        cyc(16'h0010, 1, 16'h0020, 1, 1, 16'h0040, 0, 16'h0022, 0);
        chk("t2_mis", s_mis, 1'b1);
        chk("t2_rpc", s_rpc, 16'h0040);
        look(16'h0020);
        chk("t2_npc", s_npc, 16'h0040);
        chk("t2_smis", stat_mispredicts, 32'd1);

        // 3. Counter saturates at 0, then climbs to 1 (still not taken)
        cyc(16'h0020, 1, 16'h0020, 1, 0, 16'h0000, 1, 16'h0040, 0);
        look(16'h0020);
        chk("t3_tk_after1", s_taken, 1'b0);
        cyc(16'h0020, 1, 16'h0020, 1, 0, 16'h0000, 0, 16'h0022, 0);
        cyc(16'h0020, 1, 16'h0020, 1, 0, 16'h0000, 0, 16'h0022, 0);
        cyc(16'h0020, 1, 16'h0020, 1, 1, 16'h0040, 0, 16'h0022, 0);
        look(16'h0020);
        chk("t3_tk_ctr1", s_taken, 1'b0);
        chk("t3_hit_ctr1", s_hit, 1'b1);

        // 4. Alias replaces the entry at idx 0
        cyc(16'h0000, 1, 16'h0060, 1, 1, 16'h0100, 0, 16'h0062, 0);
        look(16'h0020);
        chk("t4_alias_miss", s_hit, 1'b0);
        look(16'h0060);
        chk("t4_npc", s_npc, 16'h0100);

        // 5. invalidate_all overrides a same-cycle allocation
        cyc(16'h0060, 1, 16'h0080, 1, 1, 16'h0200, 0, 16'h0082, 1);
        look(16'h0080);
        chk("t5_miss80", s_hit, 1'b0);
        look(16'h0060);
        chk("t5_miss60", s_hit, 1'b0);

        // 6. No bypass: same-cycle update is seen next cycle
        cyc(16'h0020, 1, 16'h0020, 1, 1, 16'h0300, 0, 16'h0022, 0);
        chk("t6_old", s_hit, 1'b0);
        look(16'h0020);
        chk("t6_new", s_npc, 16'h0300);

        // Non-branch hit clears the entry and flushes a taken prediction
        cyc(16'h0020, 1, 16'h0020, 0, 0, 16'h0000, 1, 16'h0300, 0);
        chk("nb_mis", s_mis, 1'b1);
        chk("nb_rpc", s_rpc, 16'h0022);
        look(16'h0020);
        chk("nb_clear", s_hit, 1'b0);

        // pc+2 wrap on both paths; wrong predicted target also mispredicts
        cyc(16'hFFFE, 1, 16'hFFFE, 1, 0, 16'h0000, 0, 16'h0000, 0);
        chk("wrap_npc", s_npc, 16'h0000);
        chk("wrap_rpc", s_rpc, 16'h0000);
        cyc(16'h0000, 1, 16'h0040, 1, 1, 16'h0500, 1, 16'h0400, 0);
        chk("tgt_mis", s_mis, 1'b1);

        // Random traffic on a few aliasing pcs; drives stats into saturation
        for (int n = 0; n < 300; n++) begin
            logic [15:0] pcs [6];
            pcs = '{16'h0020, 16'h0060, 16'h0080, 16'h0022, 16'hFFFE, 16'h0040};
            cyc(pcs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                pcs[$urandom_range(0, 5)], 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), pcs[$urandom_range(0, 5)],
                1'($urandom_range(0, 1)), pcs[$urandom_range(0, 5)],
                ($urandom_range(0, 40) == 0));
        end
        chk("stat_hits_sat", stat_hits, 32'(C_SMAX));
        chk("stat_mis_sat",  stat_mispredicts, 32'(C_SMAX));

        // Mid-run async reset clears everything immediately
        cyc(16'h0020, 1, 16'h0020, 1, 1, 16'h0700, 0, 16'h0022, 0);
        @(negedge clk);
        if_pc = 16'h0020; upd_valid = 1'b0; invalidate_all = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        sample_and_check();
        chk("mid_rst_hit",  pred_hit, 1'b0);
        chk("mid_rst_stat", stat_hits, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        look(16'h0020);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
